// File: rtl/norm_pkg.sv
// Shared widths, the stage-register struct and small helpers for the normalizer pipeline.
package norm_pkg;

   localparam int NORM_MW = 24;
   localparam int NORM_EW = 8;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++)
         if ((1 << r) < v) r = r + 1;
      return r;
   endfunction

   // Count must reach MW itself (all-zero mantissa), hence MW+1 codes.
   localparam int NORM_LZW = clog2(NORM_MW + 1);

   typedef struct packed {
      logic                sign;
      logic [NORM_EW-1:0]  exp;
      logic [NORM_MW-1:0]  mant;
      logic                zero;
      logic                subn;
   } norm_t;

   // Leading zeros of one byte, 8 when the byte is empty.
   function automatic logic [3:0] lzc8(input logic [7:0] b);
      logic [3:0] n;
      n = 4'd8;
      for (int i = 0; i < 8; i++)
         if (b[i]) n = 4'(7 - i);
      return n;
   endfunction

endpackage

// File: rtl/lzc_w.sv
// Leading-zero counter: per-byte leaves combined by priority, MSB byte first.
module lzc_w
   import norm_pkg::*;
#(
   parameter int MW  = NORM_MW,
   parameter int LZW = NORM_LZW
) (
   input  logic [MW-1:0]  din,
   output logic [LZW-1:0] lz
);

   localparam int NB = MW / 8;

   logic [3:0]    leaf_cnt [NB];
   logic [NB-1:0] leaf_nz;

   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_leaf
         assign leaf_cnt[gi] = lzc8(din[MW-1-8*gi -: 8]);
         assign leaf_nz[gi]  = |din[MW-1-8*gi -: 8];
      end
   endgenerate

   // Walk from the least significant byte up so the most significant non-empty byte wins.
   always_comb begin
      lz = LZW'(MW);
      for (int i = NB - 1; i >= 0; i--)
         if (leaf_nz[i]) lz = LZW'(8 * i) + LZW'(leaf_cnt[i]);
   end

endmodule

// File: rtl/norm_shift_pipe.sv
// Two-stage normalizer: S1 registers the operand and its leading-zero count, S2 the
// shifted/clamped result. Stage data widths follow the norm_pkg defaults.
module norm_shift_pipe
   import norm_pkg::*;
#(
   parameter int MW  = NORM_MW,
   parameter int EW  = NORM_EW,
   parameter int LZW = NORM_LZW
) (
   input  logic          CLK,
   input  logic          RESETn,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          in_sign,
   input  logic [EW-1:0] in_exp,
   input  logic [MW-1:0] in_mant,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_sign,
   output logic [EW-1:0] out_exp,
   output logic [MW-1:0] out_mant,
   output logic          out_zero,
   output logic          out_subn
);

   logic           rst_done_q, rst_done_d;
   logic           s1_valid_q, s1_valid_d;
   logic           s1_sign_q,  s1_sign_d;
   logic [EW-1:0]  s1_exp_q,   s1_exp_d;
   logic [MW-1:0]  s1_mant_q,  s1_mant_d;
   logic [LZW-1:0] s1_lz_q,    s1_lz_d;
   logic           s2_valid_q, s2_valid_d;
   norm_t          s2_q,       s2_d;

   logic           s1_adv, s2_adv;
   logic [LZW-1:0] in_lz;
   logic [EW:0]    eff, lz_ext;
   logic [LZW-1:0] shamt;
   norm_t          res;

   lzc_w #(.MW(MW), .LZW(LZW)) u_lzc (
      .din (in_mant),
      .lz  (in_lz)
   );

   always_comb begin
      s2_adv   = ~s2_valid_q | out_ready;
      s1_adv   = ~s1_valid_q | s2_adv;
      // Held low until the first edge after reset release.
      in_ready = rst_done_q & s1_adv;
   end

   // Subnormal clamp: never shift further than leaves the biased exponent at 1.
   always_comb begin
      eff    = (s1_exp_q == '0) ? (EW+1)'(1) : {1'b0, s1_exp_q};
      lz_ext = (EW+1)'(s1_lz_q);
      shamt  = '0;
      res    = '0;
      res.sign = s1_sign_q;
      if (s1_mant_q == '0) begin
         res.zero = 1'b1;
      end else if (eff > lz_ext) begin
         shamt   = s1_lz_q;
         res.exp = EW'(eff - lz_ext);
      end else begin
         shamt    = LZW'(eff - (EW+1)'(1));
         res.subn = 1'b1;
      end
      res.mant = s1_mant_q << shamt;
   end

   always_comb begin
      rst_done_d = 1'b1;
      s1_valid_d = s1_valid_q;
      s1_sign_d  = s1_sign_q;
      s1_exp_d   = s1_exp_q;
      s1_mant_d  = s1_mant_q;
      s1_lz_d    = s1_lz_q;
      s2_valid_d = s2_valid_q;
      s2_d       = s2_q;
      if (s1_adv) begin
         s1_valid_d = in_valid & in_ready;
         if (in_valid & in_ready) begin
            s1_sign_d = in_sign;
            s1_exp_d  = in_exp;
            s1_mant_d = in_mant;
            s1_lz_d   = in_lz;
         end
      end
      if (s2_adv) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) s2_d = res;
      end
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         rst_done_q <= 1'b0;
         s1_valid_q <= 1'b0;
         s1_sign_q  <= 1'b0;
         s1_exp_q   <= '0;
         s1_mant_q  <= '0;
         s1_lz_q    <= '0;
         s2_valid_q <= 1'b0;
         s2_q       <= '0;
      end else begin
         rst_done_q <= rst_done_d;
         s1_valid_q <= s1_valid_d;
         s1_sign_q  <= s1_sign_d;
         s1_exp_q   <= s1_exp_d;
         s1_mant_q  <= s1_mant_d;
         s1_lz_q    <= s1_lz_d;
         s2_valid_q <= s2_valid_d;
         s2_q       <= s2_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign out_sign  = s2_q.sign;
   assign out_exp   = s2_q.exp;
   assign out_mant  = s2_q.mant;
   assign out_zero  = s2_q.zero;
   assign out_subn  = s2_q.subn;

endmodule
